sdc_cmd_sched: RTL and testbench

SD-card SPI command scheduler that shares one byte-level SPI engine between two requesters: requester 0 (card init) and requester 1 (block read/write). It arbitrates requests and frames each transaction: CS assert, 6-byte SD command, R1 polling, then CS release with trailing clocks. It reports the R1 byte or a timeout to the granted requester. It sits between the init/data sequencers and the SPI byte engine, clocked by the SPI-rate clock.

---
 rtl/sdc_cmd_sched_if.sv | 14 +
 rtl/sdc_cmd_sched.sv | 245 ++++++++++++++++++++++++
 tb/tb_sdc_cmd_sched.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdc_cmd_sched_if.sv
// Byte-level link between the SD command scheduler and the SPI byte engine.
// Handshake: o_byte_start pulses one cycle with o_byte_tx valid and held until the
// engine answers with a one-cycle i_byte_done carrying i_byte_rx; one byte in flight.
interface sdc_cmd_sched_if;
  logic       o_byte_start;
  logic [7:0] o_byte_tx;
  logic       i_byte_done;
  logic [7:0] i_byte_rx;

  modport master (output o_byte_start, output o_byte_tx,
                  input  i_byte_done,  input  i_byte_rx);
  modport slave  (input  o_byte_start, input  o_byte_tx,
                  output i_byte_done,  output i_byte_rx);
endinterface

// File: rtl/sdc_cmd_sched.sv
// Two-requester SD-card SPI command scheduler: arbitrates, frames CS/command/R1 poll/tail.
// Optional macro SDC_SCHED_CRC7_EN: compute CRC7 internally instead of using i_crc0/i_crc1.
module sdc_cmd_sched #(
  parameter int R1_POLL_MAX = 8,
  parameter int TAIL_BYTES  = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic [5:0]  i_cmd0,
  input  logic [5:0]  i_cmd1,
  input  logic [31:0] i_arg0,
  input  logic [31:0] i_arg1,
  input  logic [6:0]  i_crc0,
  input  logic [6:0]  i_crc1,
  output logic        o_gnt0,
  output logic        o_gnt1,
  output logic        o_done,
  output logic [7:0]  o_r1,
  output logic        o_timeout,
  output logic        o_cs,
  output logic [2:0]  o_dbg_state,
  sdc_cmd_sched_if.master eng
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_CMD  = 3'd2,
    S_POLL = 3'd3,
    S_TAIL = 3'd4,
    S_DONE = 3'd5
  } state_e;

  localparam logic [7:0] POLL_MAX_B = 8'(R1_POLL_MAX);
  localparam logic [3:0] TAIL_MAX_B = 4'(TAIL_BYTES);

  state_e      state_q, state_d;
  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic        last_q, last_d;
  logic [5:0]  cmd_q, cmd_d;
  logic [31:0] arg_q, arg_d;
  logic [6:0]  crc_q, crc_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  poll_cnt_q, poll_cnt_d;
  logic [3:0]  tail_cnt_q, tail_cnt_d;
  logic [7:0]  r1_q, r1_d;
  logic        timeout_q, timeout_d;
  logic        busy_q, busy_d;
  logic        start_q, start_d;
  logic [7:0]  tx_q, tx_d;
  logic        cs_q, cs_d;
  logic        done_q, done_d;

  logic        any_req, win1, byte_ev;
  logic [5:0]  sel_cmd;
  logic [31:0] sel_arg;
  logic [6:0]  sel_crc;

  function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [5:0] c,
                                          input logic [31:0] a, input logic [6:0] r);
    case (idx)
      3'd0:    cmd_byte = {2'b01, c};
      3'd1:    cmd_byte = a[31:24];
      3'd2:    cmd_byte = a[23:16];
      3'd3:    cmd_byte = a[15:8];
      3'd4:    cmd_byte = a[7:0];
      3'd5:    cmd_byte = {r, 1'b1};
      default: cmd_byte = 8'hFF;
    endcase
  endfunction

  // Tie goes to whoever was not served last; last_q resets to 1 so requester 0 wins first.
  assign any_req = i_req0 | i_req1;
  assign win1    = i_req1 & (~i_req0 | ~last_q);
  assign sel_cmd = win1 ? i_cmd1 : i_cmd0;
  assign sel_arg = win1 ? i_arg1 : i_arg0;
  assign byte_ev = busy_q & eng.i_byte_done;

`ifdef SDC_SCHED_CRC7_EN
  function automatic logic [6:0] crc7_calc(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    crc7_calc = c;
  endfunction

  logic unused_crc_in;
  assign unused_crc_in = ^{i_crc0, i_crc1};
  assign sel_crc       = crc7_calc({2'b01, sel_cmd, sel_arg});
`else
  assign sel_crc = win1 ? i_crc1 : i_crc0;
`endif

  always_comb begin
    state_d    = state_q;
    gnt0_d     = gnt0_q;
    gnt1_d     = gnt1_q;
    last_d     = last_q;
    cmd_d      = cmd_q;
    arg_d      = arg_q;
    crc_d      = crc_q;
    idx_d      = idx_q;
    poll_cnt_d = poll_cnt_q;
    tail_cnt_d = tail_cnt_q;
    r1_d       = r1_q;
    timeout_d  = timeout_q;
    tx_d       = tx_q;
    cs_d       = cs_q;
    start_d    = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d    = S_PRE;
          gnt0_d     = ~win1;
          gnt1_d     = win1;
          last_d     = win1;
          cmd_d      = sel_cmd;
          arg_d      = sel_arg;
          crc_d      = sel_crc;
          idx_d      = 3'd0;
          poll_cnt_d = 8'd0;
          tail_cnt_d = 4'd0;
          cs_d       = 1'b0;
          start_d    = 1'b1;
          tx_d       = 8'hFF;
        end
      end
      S_PRE: begin
        if (byte_ev) begin
          state_d = S_CMD;
          idx_d   = 3'd0;
          start_d = 1'b1;
          tx_d    = cmd_byte(3'd0, cmd_q, arg_q, crc_q);
        end
      end
      S_CMD: begin
        if (byte_ev) begin
          start_d = 1'b1;
          if (idx_q == 3'd5) begin
            state_d    = S_POLL;
            poll_cnt_d = 8'd0;
            tx_d       = 8'hFF;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = cmd_byte(idx_q + 3'd1, cmd_q, arg_q, crc_q);
          end
        end
      end
      S_POLL: begin
        if (byte_ev) begin
          poll_cnt_d = poll_cnt_q + 8'd1;
          start_d    = 1'b1;
          tx_d       = 8'hFF;
          if (!eng.i_byte_rx[7] || (poll_cnt_q + 8'd1 == POLL_MAX_B)) begin
            r1_d       = eng.i_byte_rx[7] ? 8'hFF : eng.i_byte_rx;
            timeout_d  = eng.i_byte_rx[7];
            state_d    = S_TAIL;
            tail_cnt_d = 4'd0;
            cs_d       = 1'b1;
          end
        end
      end
      S_TAIL: begin
        if (byte_ev) begin
          tail_cnt_d = tail_cnt_q + 4'd1;
          if (tail_cnt_q + 4'd1 == TAIL_MAX_B) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            start_d = 1'b1;
            tx_d    = 8'hFF;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (busy_q & ~eng.i_byte_done) | start_d;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      last_q     <= 1'b1;
      cmd_q      <= 6'd0;
      arg_q      <= 32'd0;
      crc_q      <= 7'd0;
      idx_q      <= 3'd0;
      poll_cnt_q <= 8'd0;
      tail_cnt_q <= 4'd0;
      r1_q       <= 8'hFF;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      tx_q       <= 8'hFF;
      cs_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      last_q     <= last_d;
      cmd_q      <= cmd_d;
      arg_q      <= arg_d;
      crc_q      <= crc_d;
      idx_q      <= idx_d;
      poll_cnt_q <= poll_cnt_d;
      tail_cnt_q <= tail_cnt_d;
      r1_q       <= r1_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
      start_q    <= start_d;
      tx_q       <= tx_d;
      cs_q       <= cs_d;
      done_q     <= done_d;
    end
  end

  assign o_gnt0           = gnt0_q;
  assign o_gnt1           = gnt1_q;
  assign o_done           = done_q;
  assign o_r1             = r1_q;
  assign o_timeout        = timeout_q;
  assign o_cs             = cs_q;
  assign o_dbg_state      = state_q;
  assign eng.o_byte_start = start_q;
  assign eng.o_byte_tx    = tx_q;

endmodule

// File: tb/tb_sdc_cmd_sched.sv
// Directed bench for sdc_cmd_sched with a zero-wait SPI byte engine model.
module tb_sdc_cmd_sched;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_POLL = 3'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req0, req1;
  logic [5:0]  cmd0, cmd1;
  logic [31:0] arg0, arg1;
  logic [6:0]  crc0, crc1;
  logic        gnt0, gnt1, done, timeout, cs;
  logic [7:0]  r1;
  logic [2:0]  dbg_state;

  sdc_cmd_sched_if sched_if();

  sdc_cmd_sched #(.R1_POLL_MAX(8), .TAIL_BYTES(1)) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_req0(req0), .i_req1(req1),
    .i_cmd0(cmd0), .i_cmd1(cmd1),
    .i_arg0(arg0), .i_arg1(arg1),
    .i_crc0(crc0), .i_crc1(crc1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_done(done),
    .o_r1(r1), .o_timeout(timeout), .o_cs(cs),
    .o_dbg_state(dbg_state),
    .eng(sched_if)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] tx_log[$];
  logic       cs_log[$];
  logic [7:0] rsp_tbl[0:15];
  int         rsp_len = 0;
  logic [7:0] rsp_fill = 8'hFF;
  logic       spur_tog = 1'b0;
  int         done_cnt = 0;
  int         overlap_cnt = 0;

  // Engine model: answers every start on the following edge, logs tx byte and CS level.
  logic eng_spur_seen = 1'b0;
  int   eng_pos = 0;
  always @(negedge clk) begin
    sched_if.i_byte_done = 1'b0;
    if (rst_n === 1'b1 && sched_if.o_byte_start === 1'b1) begin
      if (dbg_state == ST_PRE) eng_pos = 0;
      else eng_pos = eng_pos + 1;
      tx_log.push_back(sched_if.o_byte_tx);
      cs_log.push_back(cs);
      sched_if.i_byte_rx   = (eng_pos < rsp_len) ? rsp_tbl[eng_pos] : rsp_fill;
      sched_if.i_byte_done = 1'b1;
    end else if (spur_tog != eng_spur_seen) begin
      eng_spur_seen        = spur_tog;
      sched_if.i_byte_rx   = 8'h00;
      sched_if.i_byte_done = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt = done_cnt + 1;
    if (gnt0 === 1'b1 && gnt1 === 1'b1) overlap_cnt = overlap_cnt + 1;
  end

  task automatic wait_done(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        seen = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    cmd0 = '0; cmd1 = '0; arg0 = '0; arg1 = '0; crc0 = '0; crc1 = '0;
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++; if (cs !== 1'b1) begin err_cnt++; $display("FAIL rst_cs: got %b expected 1", cs); end
    vec_cnt++; if (gnt0 !== 1'b0) begin err_cnt++; $display("FAIL rst_gnt0: got %b expected 0", gnt0); end
    vec_cnt++; if (gnt1 !== 1'b0) begin err_cnt++; $display("FAIL rst_gnt1: got %b expected 0", gnt1); end
    vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL rst_done: got %b expected 0", done); end
    vec_cnt++; if (timeout !== 1'b0) begin err_cnt++; $display("FAIL rst_timeout: got %b expected 0", timeout); end
    vec_cnt++; if (r1 !== 8'hFF) begin err_cnt++; $display("FAIL rst_r1: got %h expected ff", r1); end
    vec_cnt++; if (sched_if.o_byte_start !== 1'b0) begin err_cnt++; $display("FAIL rst_start: got %b expected 0", sched_if.o_byte_start); end
    vec_cnt++; if (sched_if.o_byte_tx !== 8'hFF) begin err_cnt++; $display("FAIL rst_tx: got %h expected ff", sched_if.o_byte_tx); end
    vec_cnt++; if (dbg_state !== ST_IDLE) begin err_cnt++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++; if (tx_log.size() !== 0) begin err_cnt++; $display("FAIL rst_quiet: got %0d bytes expected 0", tx_log.size()); end
  endtask

  task automatic test_cmd0();
    int  base, dbase;
    bit  seen;
    base = tx_log.size(); dbase = done_cnt;
    for (int i = 0; i < 8; i++) rsp_tbl[i] = 8'hFF;
    rsp_tbl[8] = 8'h01; rsp_len = 9; rsp_fill = 8'hFF;
    cmd0 = 6'd0; arg0 = 32'h0; crc0 = 7'h4A; req0 = 1'b1;
    @(posedge clk); #1;
    vec_cnt++; if (gnt0 !== 1'b1) begin err_cnt++; $display("FAIL lat_gnt0: got %b expected 1", gnt0); end
    vec_cnt++; if (cs !== 1'b0) begin err_cnt++; $display("FAIL lat_cs: got %b expected 0", cs); end
    vec_cnt++; if (sched_if.o_byte_start !== 1'b1) begin err_cnt++; $display("FAIL lat_start: got %b expected 1", sched_if.o_byte_start); end
    vec_cnt++; if (sched_if.o_byte_tx !== 8'hFF) begin err_cnt++; $display("FAIL lat_tx: got %h expected ff", sched_if.o_byte_tx); end
    wait_done(100, seen);
    vec_cnt++; if (seen !== 1'b1) begin err_cnt++; $display("FAIL cmd0_done: got %b expected 1", seen); end
    vec_cnt++; if (r1 !== 8'h01) begin err_cnt++; $display("FAIL cmd0_r1: got %h expected 01", r1); end
    vec_cnt++; if (timeout !== 1'b0) begin err_cnt++; $display("FAIL cmd0_timeout: got %b expected 0", timeout); end
    vec_cnt++; if (gnt0 !== 1'b1) begin err_cnt++; $display("FAIL cmd0_gnt_at_done: got %b expected 1", gnt0); end
    @(posedge clk); #1;
    req0 = 1'b0;
    vec_cnt++; if (gnt0 !== 1'b0) begin err_cnt++; $display("FAIL cmd0_gnt_drop: got %b expected 0", gnt0); end
    vec_cnt++; if (dbg_state !== ST_IDLE) begin err_cnt++; $display("FAIL cmd0_idle: got %0d expected 0", dbg_state); end
    repeat (4) @(posedge clk);
    #1;
    vec_cnt++; if (done_cnt - dbase !== 1) begin err_cnt++; $display("FAIL cmd0_done_cnt: got %0d expected 1", done_cnt - dbase); end
    exp_q = '{8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF, 8'hFF};
    vec_cnt++; if (tx_log.size() - base !== 10) begin err_cnt++; $display("FAIL cmd0_len: got %0d expected 10", tx_log.size() - base); end
    for (int i = 0; i < exp_q.size() && base + i < tx_log.size(); i++) begin
      vec_cnt++;
      if (tx_log[base+i] !== exp_q[i]) begin err_cnt++; $display("FAIL cmd0_tx[%0d]: got %h expected %h", i, tx_log[base+i], exp_q[i]); end
      vec_cnt++;
      if (cs_log[base+i] !== (i == 9)) begin err_cnt++; $display("FAIL cmd0_cs[%0d]: got %b expected %b", i, cs_log[base+i], (i == 9)); end
    end
  endtask

  task automatic test_crc8();
    int         base;
    bit         seen;
    logic [7:0] exp_crc;
`ifdef SDC_SCHED_CRC7_EN
    exp_crc = 8'h87;
`else
    exp_crc = 8'h01;
`endif
    base = tx_log.size();
    rsp_len = 0; rsp_fill = 8'h01;
    cmd0 = 6'd8; arg0 = 32'h0000_01AA; crc0 = 7'h00; req0 = 1'b1;
    wait_done(100, seen);
    @(posedge clk); #1;
    req0 = 1'b0;
    vec_cnt++; if (seen !== 1'b1) begin err_cnt++; $display("FAIL crc8_done: got %b expected 1", seen); end
    vec_cnt++; if (tx_log.size() - base !== 9) begin err_cnt++; $display("FAIL crc8_len: got %0d expected 9", tx_log.size() - base); end
    if (tx_log.size() - base >= 7) begin
      vec_cnt++; if (tx_log[base+1] !== 8'h48) begin err_cnt++; $display("FAIL crc8_b0: got %h expected 48", tx_log[base+1]); end
      vec_cnt++; if (tx_log[base+5] !== 8'hAA) begin err_cnt++; $display("FAIL crc8_b4: got %h expected aa", tx_log[base+5]); end
      vec_cnt++; if (tx_log[base+6] !== exp_crc) begin err_cnt++; $display("FAIL crc8_crc: got %h expected %h", tx_log[base+6], exp_crc); end
    end
    vec_cnt++; if (r1 !== 8'h01) begin err_cnt++; $display("FAIL crc8_r1: got %h expected 01", r1); end
  endtask

  task automatic test_timeout();
    int base, hi_cnt;
    bit seen;
    base = tx_log.size();
    rsp_len = 0; rsp_fill = 8'hFF;
    cmd1 = 6'd17; arg1 = 32'h0000_0200; crc1 = 7'h2A; req1 = 1'b1;
    wait_done(200, seen);
    vec_cnt++; if (seen !== 1'b1) begin err_cnt++; $display("FAIL to_done: got %b expected 1", seen); end
    vec_cnt++; if (timeout !== 1'b1) begin err_cnt++; $display("FAIL to_flag: got %b expected 1", timeout); end
    vec_cnt++; if (r1 !== 8'hFF) begin err_cnt++; $display("FAIL to_r1: got %h expected ff", r1); end
    vec_cnt++; if (gnt1 !== 1'b1) begin err_cnt++; $display("FAIL to_gnt1: got %b expected 1", gnt1); end
    @(posedge clk); #1;
    req1 = 1'b0;
    vec_cnt++; if (tx_log.size() - base !== 16) begin err_cnt++; $display("FAIL to_len: got %0d expected 16", tx_log.size() - base); end
    hi_cnt = 0;
    for (int i = base; i < tx_log.size(); i++) if (cs_log[i] === 1'b1) hi_cnt++;
    vec_cnt++; if (hi_cnt !== 1) begin err_cnt++; $display("FAIL to_cs_hi: got %0d expected 1", hi_cnt); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_own[3];
    int         ov_base;
    bit         seen;
    exp_own[0] = 2'b01; exp_own[1] = 2'b10; exp_own[2] = 2'b01;
    ov_base = overlap_cnt;
    rsp_len = 0; rsp_fill = 8'h05;
    cmd0 = 6'd0; arg0 = 32'h0; crc0 = 7'h4A;
    cmd1 = 6'd16; arg1 = 32'h200; crc1 = 7'h0A;
    req0 = 1'b1; req1 = 1'b1;
    for (int t = 0; t < 3; t++) begin
      wait_done(100, seen);
      vec_cnt++; if (seen !== 1'b1) begin err_cnt++; $display("FAIL rr_done[%0d]: got %b expected 1", t, seen); end
      vec_cnt++; if ({gnt1, gnt0} !== exp_own[t]) begin err_cnt++; $display("FAIL rr_owner[%0d]: got %b expected %b", t, {gnt1, gnt0}, exp_own[t]); end
      vec_cnt++; if (r1 !== 8'h05) begin err_cnt++; $display("FAIL rr_r1[%0d]: got %h expected 05", t, r1); end
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++; if (overlap_cnt - ov_base !== 0) begin err_cnt++; $display("FAIL rr_overlap: got %0d expected 0", overlap_cnt - ov_base); end
    vec_cnt++; if (dbg_state !== ST_IDLE) begin err_cnt++; $display("FAIL rr_idle: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_reset_mid();
    int  base, dbase;
    bit  found, seen;
    base = tx_log.size(); dbase = done_cnt; found = 1'b0;
    rsp_len = 0; rsp_fill = 8'h01;
    cmd0 = 6'd17; arg0 = 32'h1234_5678; crc0 = 7'h11; req0 = 1'b1;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk); #1;
      if (sched_if.o_byte_start === 1'b1 && tx_log.size() - base == 4) found = 1'b1;
    end
    vec_cnt++; if (found !== 1'b1) begin err_cnt++; $display("FAIL rm_reach: got %b expected 1", found); end
    vec_cnt++; if (sched_if.o_byte_tx !== 8'h56) begin err_cnt++; $display("FAIL rm_byte3: got %h expected 56", sched_if.o_byte_tx); end
    rst_n = 1'b0; req0 = 1'b0;
    @(posedge clk); #1;
    vec_cnt++; if (cs !== 1'b1) begin err_cnt++; $display("FAIL rm_cs: got %b expected 1", cs); end
    vec_cnt++; if (gnt0 !== 1'b0) begin err_cnt++; $display("FAIL rm_gnt: got %b expected 0", gnt0); end
    vec_cnt++; if (sched_if.o_byte_start !== 1'b0) begin err_cnt++; $display("FAIL rm_start: got %b expected 0", sched_if.o_byte_start); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    vec_cnt++; if (tx_log.size() - base !== 4) begin err_cnt++; $display("FAIL rm_quiet: got %0d bytes expected 4", tx_log.size() - base); end
    vec_cnt++; if (done_cnt - dbase !== 0) begin err_cnt++; $display("FAIL rm_no_done: got %0d expected 0", done_cnt - dbase); end
    vec_cnt++; if (dbg_state !== ST_IDLE) begin err_cnt++; $display("FAIL rm_idle: got %0d expected 0", dbg_state); end
    base = tx_log.size();
    cmd0 = 6'd0; arg0 = 32'h0; crc0 = 7'h4A; req0 = 1'b1;
    wait_done(100, seen);
    @(posedge clk); #1;
    req0 = 1'b0;
    vec_cnt++; if (seen !== 1'b1) begin err_cnt++; $display("FAIL rm_redo_done: got %b expected 1", seen); end
    exp_q = '{8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF};
    vec_cnt++; if (tx_log.size() - base !== 9) begin err_cnt++; $display("FAIL rm_redo_len: got %0d expected 9", tx_log.size() - base); end
    for (int i = 0; i < exp_q.size() && base + i < tx_log.size(); i++) begin
      vec_cnt++;
      if (tx_log[base+i] !== exp_q[i]) begin err_cnt++; $display("FAIL rm_redo_tx[%0d]: got %h expected %h", i, tx_log[base+i], exp_q[i]); end
    end
  endtask

  task automatic test_drop_req();
    int  base, dbase;
    bit  found, seen;
    base = tx_log.size(); dbase = done_cnt; found = 1'b0;
    rsp_len = 0; rsp_fill = 8'hFF;
    cmd1 = 6'd17; arg1 = 32'h0; crc1 = 7'h2A; req1 = 1'b1;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk); #1;
      if (dbg_state === ST_POLL) found = 1'b1;
    end
    req1 = 1'b0;
    vec_cnt++; if (found !== 1'b1) begin err_cnt++; $display("FAIL dr_reach_poll: got %b expected 1", found); end
    wait_done(100, seen);
    vec_cnt++; if (seen !== 1'b1) begin err_cnt++; $display("FAIL dr_done: got %b expected 1", seen); end
    vec_cnt++; if (gnt1 !== 1'b1) begin err_cnt++; $display("FAIL dr_gnt_at_done: got %b expected 1", gnt1); end
    @(posedge clk); #1;
    vec_cnt++; if (gnt1 !== 1'b0) begin err_cnt++; $display("FAIL dr_gnt_drop: got %b expected 0", gnt1); end
    repeat (5) @(posedge clk);
    #1;
    vec_cnt++; if (dbg_state !== ST_IDLE) begin err_cnt++; $display("FAIL dr_idle: got %0d expected 0", dbg_state); end
    vec_cnt++; if (tx_log.size() - base !== 16) begin err_cnt++; $display("FAIL dr_len: got %0d expected 16", tx_log.size() - base); end
    vec_cnt++; if (done_cnt - dbase !== 1) begin err_cnt++; $display("FAIL dr_done_cnt: got %0d expected 1", done_cnt - dbase); end
  endtask

  task automatic test_spurious();
    int  base, dbase;
    bit  seen;
    base = tx_log.size(); dbase = done_cnt;
    spur_tog = ~spur_tog;
    repeat (4) @(posedge clk);
    #1;
    vec_cnt++; if (tx_log.size() - base !== 0) begin err_cnt++; $display("FAIL sp_no_tx: got %0d expected 0", tx_log.size() - base); end
    vec_cnt++; if (done_cnt - dbase !== 0) begin err_cnt++; $display("FAIL sp_no_done: got %0d expected 0", done_cnt - dbase); end
    vec_cnt++; if (r1 !== 8'hFF) begin err_cnt++; $display("FAIL sp_r1: got %h expected ff", r1); end
    vec_cnt++; if (dbg_state !== ST_IDLE) begin err_cnt++; $display("FAIL sp_idle: got %0d expected 0", dbg_state); end
    rsp_len = 0; rsp_fill = 8'h00;
    cmd0 = 6'd55; arg0 = 32'h0; crc0 = 7'h32; req0 = 1'b1;
    wait_done(100, seen);
    @(posedge clk); #1;
    req0 = 1'b0;
    vec_cnt++; if (seen !== 1'b1) begin err_cnt++; $display("FAIL sp_next_done: got %b expected 1", seen); end
    vec_cnt++; if (tx_log.size() - base !== 9) begin err_cnt++; $display("FAIL sp_next_len: got %0d expected 9", tx_log.size() - base); end
    vec_cnt++; if (r1 !== 8'h00) begin err_cnt++; $display("FAIL sp_next_r1: got %h expected 00", r1); end
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_crc8();
    test_timeout();
    test_round_robin();
    test_reset_mid();
    test_drop_req();
    test_spurious();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
